// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver for the stopwatch datapath.
// Frame-synchronous snapshot of the digit fields, BCD split, blink, dp and leading-zero blanking.
module seg_scan_driver #(
    parameter int SCAN_CNT     = 100000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [5:0] digit12,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_en,
    input  logic [3:0] dp_mask,
    input  logic       lz_blank,
    output logic [3:0] digit_display,
    output logic [7:0] segs,
    output logic       frame_start
);

    localparam int SCAN_W  = $clog2(SCAN_CNT);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CNT - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    // Segment pattern {g,f,e,d,c,b,a}, active-low; hex digits for 10..15.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'h40;
            4'h1:    p = 7'h79;
            4'h2:    p = 7'h24;
            4'h3:    p = 7'h30;
            4'h4:    p = 7'h19;
            4'h5:    p = 7'h12;
            4'h6:    p = 7'h02;
            4'h7:    p = 7'h78;
            4'h8:    p = 7'h00;
            4'h9:    p = 7'h10;
            4'hA:    p = 7'h08;
            4'hB:    p = 7'h03;
            4'hC:    p = 7'h46;
            4'hD:    p = 7'h21;
            4'hE:    p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         sh_d0_q, sh_d0_d;
    logic [5:0]         sh_d12_q, sh_d12_d;
    logic [3:0]         sh_d3_q, sh_d3_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         segs_q, segs_d;
    logic               frame_start_q, frame_start_d;

    logic       slot_end;
    logic       snap;
    logic       dash;
    logic [3:0] tens;
    logic [5:0] tens_x10;
    logic [3:0] ones;
    logic [3:0] slot_val;
    logic       slot_blank;
    logic       slot_hidden;

    // Scan timing, snapshot and blink frame counting.
    always_comb begin
        slot_end      = (scan_cnt_q == SCAN_LAST);
        snap          = slot_end && (idx_q == 2'd3);
        scan_cnt_d    = slot_end ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d         = slot_end ? idx_q + 2'd1 : idx_q;
        sh_d0_d       = sh_d0_q;
        sh_d12_d      = sh_d12_q;
        sh_d3_d       = sh_d3_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_start_d = snap;
        if (snap) begin
            sh_d0_d  = digit0;
            sh_d12_d = digit12;
            sh_d3_d  = digit3;
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    // Binary 0..59 to tens/ones by comparison chain; 60..63 shows dashes.
    always_comb begin
        dash = (sh_d12_q >= 6'd60);
        if (sh_d12_q >= 6'd50) begin
            tens = 4'd5;
        end else if (sh_d12_q >= 6'd40) begin
            tens = 4'd4;
        end else if (sh_d12_q >= 6'd30) begin
            tens = 4'd3;
        end else if (sh_d12_q >= 6'd20) begin
            tens = 4'd2;
        end else if (sh_d12_q >= 6'd10) begin
            tens = 4'd1;
        end else begin
            tens = 4'd0;
        end
        case (tens)
            4'd5:    tens_x10 = 6'd50;
            4'd4:    tens_x10 = 6'd40;
            4'd3:    tens_x10 = 6'd30;
            4'd2:    tens_x10 = 6'd20;
            4'd1:    tens_x10 = 6'd10;
            default: tens_x10 = 6'd0;
        endcase
        ones = 4'(sh_d12_q - tens_x10);
    end

    // Slot content, blanking and the registered display outputs.
    always_comb begin
        slot_val   = sh_d0_q;
        slot_blank = 1'b0;
        case (idx_q)
            2'd0: slot_val = sh_d0_q;
            2'd1: slot_val = ones;
            2'd2: begin
                slot_val   = tens;
                slot_blank = lz_blank && (sh_d3_q == 4'd0) && !dash && (tens == 4'd0);
            end
            default: begin
                slot_val   = sh_d3_q;
                slot_blank = lz_blank && (sh_d3_q == 4'd0);
            end
        endcase
        slot_hidden = slot_blank || (blink_phase_q && blink_en[idx_q]);
        an_d        = 4'hF;
        segs_d      = 8'hFF;
        if (!slot_hidden) begin
            an_d = ~(4'b0001 << idx_q);
            if (dash && (idx_q == 2'd1 || idx_q == 2'd2)) begin
                segs_d = {~dp_mask[idx_q], 7'h3F};
            end else begin
                segs_d = {~dp_mask[idx_q], seg7(slot_val)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            idx_q         <= 2'd0;
            sh_d0_q       <= 4'd0;
            sh_d12_q      <= 6'd0;
            sh_d3_q       <= 4'd0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'hF;
            segs_q        <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            sh_d0_q       <= sh_d0_d;
            sh_d12_q      <= sh_d12_d;
            sh_d3_q       <= sh_d3_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            segs_q        <= segs_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign digit_display = an_q;
    assign segs          = segs_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_CNT=4, BLINK_FRAMES=2 (16-cycle frames).
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit0;
    logic [5:0] digit12;
    logic [3:0] digit3;
    logic [3:0] blink_en;
    logic [3:0] dp_mask;
    logic       lz_blank;
    logic [3:0] digit_display;
    logic [7:0] segs;
    logic       frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_driver #(.SCAN_CNT(4), .BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .digit0       (digit0),
        .digit12      (digit12),
        .digit3       (digit3),
        .blink_en     (blink_en),
        .dp_mask      (dp_mask),
        .lz_blank     (lz_blank),
        .digit_display(digit_display),
        .segs         (segs),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d0;
        logic [5:0] d12;
        logic [3:0] d3;
        logic [3:0] dp;
        logic       lz;
        logic [7:0] s0, s1, s2, s3;
        logic [3:0] blank;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] an_for(input int slot, input logic off);
        logic [3:0] a;
        a = ~(4'b0001 << slot);
        return off ? 4'hF : a;
    endfunction

    // After a frame_start edge: check all 16 cycles of the frame, optionally changing digit0 mid-frame.
    task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3, input logic [3:0] blank, input int chg_at,
                               input logic [3:0] chg_val, input string tag);
        logic [7:0] e[4];
        int slot;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int j = 1; j <= 16; j++) begin
            step();
            slot = (j - 1) >> 2;
            chk($sformatf("%s segs slot%0d c%0d", tag, slot, j), segs, e[slot]);
            chk($sformatf("%s an slot%0d c%0d", tag, slot, j), {4'h0, digit_display},
                {4'h0, an_for(slot, blank[slot])});
            chk($sformatf("%s frame_start c%0d", tag, j), {7'h0, frame_start}, {7'h0, j == 16});
            if (j == chg_at) digit0 = chg_val;
        end
    endtask

    // First frame after reset release: zero shadows, frame_start only on the 16th edge.
    task automatic check_startup(input string tag);
        int slot;
        for (int k = 1; k <= 16; k++) begin
            step();
            slot = (k - 1) >> 2;
            chk($sformatf("%s segs c%0d", tag, k), segs, dp_mask[slot] ? 8'h40 : 8'hC0);
            chk($sformatf("%s an c%0d", tag, k), {4'h0, digit_display}, {4'h0, an_for(slot, 1'b0)});
            chk($sformatf("%s frame_start c%0d", tag, k), {7'h0, frame_start}, {7'h0, k == 16});
        end
    endtask

    task automatic wait_fs(input string tag);
        int  cnt = 0;
        logic seen = 1'b0;
        while (!seen && cnt < 40) begin
            step();
            cnt++;
            seen = frame_start;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s wait frame_start: got timeout after %0d cycles expected pulse", tag, cnt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " an"}, {4'h0, digit_display}, 8'h0F);
        chk({tag, " segs"}, segs, 8'hFF);
        chk({tag, " frame_start"}, {7'h0, frame_start}, 8'h00);
    endtask

    initial begin
        logic [7:0] bexp[4];
        int slot, frame;
        logic blinked;

        //            d0     d12     d3     dp       lz     AN0    AN1    AN2    AN3    blank
        vecs[0] = '{4'h7, 6'd45, 4'h3, 4'b0100, 1'b0, 8'hF8, 8'h92, 8'h19, 8'hB0, 4'b0000};
        vecs[1] = '{4'h0, 6'd60, 4'hA, 4'b0000, 1'b0, 8'hC0, 8'hBF, 8'hBF, 8'h88, 4'b0000};
        vecs[2] = '{4'h9, 6'd59, 4'hF, 4'b1000, 1'b0, 8'h90, 8'h90, 8'h92, 8'h0E, 4'b0000};
        vecs[3] = '{4'h1, 6'd5,  4'h0, 4'b0000, 1'b1, 8'hF9, 8'h92, 8'hFF, 8'hFF, 4'b1100};
        vecs[4] = '{4'hB, 6'd12, 4'h0, 4'b0001, 1'b1, 8'h03, 8'hA4, 8'hF9, 8'hFF, 4'b1000};
        vecs[5] = '{4'hC, 6'd63, 4'h0, 4'b0000, 1'b1, 8'hC6, 8'hBF, 8'hBF, 8'hFF, 4'b1000};
        vecs[6] = '{4'hD, 6'd0,  4'hE, 4'b0010, 1'b1, 8'hA1, 8'h40, 8'hC0, 8'h86, 4'b0000};
        vecs[7] = '{4'h2, 6'd30, 4'h0, 4'b0000, 1'b0, 8'hA4, 8'hC0, 8'hB0, 8'hC0, 4'b0000};
        vecs[8] = '{4'h4, 6'd7,  4'h0, 4'b1100, 1'b1, 8'h99, 8'hF8, 8'hFF, 8'hFF, 4'b1100};
        vecs[9] = '{4'h5, 6'd10, 4'h6, 4'b1111, 1'b0, 8'h12, 8'h40, 8'h79, 8'h02, 4'b0000};

        reset    = 1'b1;
        blink_en = 4'b0000;
        digit0   = vecs[0].d0;
        digit12  = vecs[0].d12;
        digit3   = vecs[0].d3;
        dp_mask  = vecs[0].dp;
        lz_blank = vecs[0].lz;

        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs($sformatf("reset hold %0d", i));
        end
        reset = 1'b0;
        check_startup("startup");
        check_frame(vecs[0].s0, vecs[0].s1, vecs[0].s2, vecs[0].s3, vecs[0].blank, -1, 4'h0, "vec0");

        for (int i = 1; i < 10; i++) begin
            digit0   = vecs[i].d0;
            digit12  = vecs[i].d12;
            digit3   = vecs[i].d3;
            dp_mask  = vecs[i].dp;
            lz_blank = vecs[i].lz;
            wait_fs($sformatf("vec%0d", i));
            check_frame(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].blank, -1, 4'h0,
                        $sformatf("vec%0d", i));
        end

        // Mid-frame input change must not tear the current frame.
        digit0   = 4'h7;
        digit12  = 6'd45;
        digit3   = 4'h3;
        dp_mask  = 4'b0000;
        lz_blank = 1'b0;
        wait_fs("midchg");
        check_frame(8'hF8, 8'h92, 8'h99, 8'hB0, 4'b0000, 5, 4'h2, "midchg old");
        check_frame(8'hA4, 8'h92, 8'h99, 8'hB0, 4'b0000, -1, 4'h0, "midchg new");

        // Move into slot 2 of the next frame, then a one-cycle reset.
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        check_reset_outputs("midreset");
        blink_en = 4'b0001;
        digit0   = 4'h8;
        digit12  = 6'd21;
        digit3   = 4'h4;
        reset    = 1'b0;
        check_startup("restart");

        // Blink phase high in frames 2-3 and 6-7, affecting AN0 only.
        bexp[0] = 8'h80; bexp[1] = 8'hF9; bexp[2] = 8'hA4; bexp[3] = 8'h99;
        for (int k = 17; k <= 128; k++) begin
            step();
            slot    = ((k - 1) >> 2) & 3;
            frame   = (k - 1) >> 4;
            blinked = (slot == 0) && (frame == 2 || frame == 3 || frame == 6 || frame == 7);
            chk($sformatf("blink f%0d segs c%0d", frame, k), segs, blinked ? 8'hFF : bexp[slot]);
            chk($sformatf("blink f%0d an c%0d", frame, k), {4'h0, digit_display},
                {4'h0, an_for(slot, blinked)});
            chk($sformatf("blink frame_start c%0d", k), {7'h0, frame_start}, {7'h0, (k % 16) == 0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
